ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. Sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the FPGA to the keyboard over the open-collector ps2k_clk/ps2k_data lines.
- Companion to the existing PS/2 receive path (ps2scan). Shares the same physical pins through top-level tri-state buffers.
- Drives lines only low via output-enables. Reports completion, device ACK status and timeout.

Parameters:
- INHIBIT_CYC, 5000: clock-inhibit hold in clk cycles (100 us at 50 MHz).
- SETUP_CYC, 50: cycles data is held low before ps2k_clk is released (1 us).
- TIMEOUT_CYC, 750000: max cycles from clock release to ACK (15 ms).

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous active-low reset
- tx_data  in  8  command byte, sampled on the accepted tx_start
- tx_start  in  1  single-cycle request; ignored while busy=1
- ps2k_clk_in  in  1  raw PS/2 clock pin level
- ps2k_data_in  in  1  raw PS/2 data pin level
- ps2k_clk_oe  out  1  1 = pull PS/2 clock low
- ps2k_data_oe  out  1  1 = pull PS/2 data low
- busy  out  1  high from accepted tx_start until return to IDLE
- done  out  1  1-cycle pulse when the frame ends (ACK, NACK or timeout)
- ack_err  out  1  1-cycle pulse coincident with done when device NACKed
- timeout  out  1  1-cycle pulse coincident with done on timeout

Behaviour:
- Reset (async, rst_n=0): all outputs 0, both lines released, FSM=IDLE, counters cleared. Reset mid-frame releases both lines immediately.
- Input conditioning: ps2k_clk_in and ps2k_data_in each pass through a 2-FF synchroniser. A falling edge is flagged when the synchronised clock goes 1→0 (3rd stage compare).
- Frame shift register is 10 bits, LSB first: data[7:0], odd parity (~^tx_data), stop=1.
- IDLE: on tx_start & !busy, latch the frame, busy←1, go to INHIBIT.
- INHIBIT: clk_oe=1, data_oe=0, for INHIBIT_CYC cycles, then go to REQ.
- REQ: clk_oe=1, data_oe=1 (start bit) for SETUP_CYC cycles. Then clk_oe←0, clear the bit counter, start the timeout counter, go to SEND.
- SEND: on each synchronised falling edge, data_oe ← ~frame[bit_cnt] and bit_cnt++. Edges 1–8 drive the data bits, edge 9 drives parity, edge 10 drives stop (line released). After the 10th edge go to ACK.
- ACK: on the next falling edge, sample ps2k_data. 0 = ACK, 1 = NACK (latched). Go to WAIT_IDLE.
- WAIT_IDLE: wait until synchronised clk=1 and data=1. Then pulse done (with ack_err if NACK), busy←0, go to IDLE.
- Timeout: the counter runs in SEND, ACK and WAIT_IDLE. On reaching TIMEOUT_CYC-1: release both lines, pulse done+timeout, busy←0, go to IDLE. Timeout takes priority over a same-cycle edge.
- tx_start asserted while busy=1 is dropped; no queueing.
- Line-level latency: clk_oe rises 1 cycle after the accepted tx_start.

Optional Feature:
- Macro: PS2_TX_RETRY_EN.
- Defined: on NACK or timeout, the first occurrence does not pulse done. Instead the FSM re-enters INHIBIT with the same latched frame. done/ack_err/timeout report only the second attempt's outcome. busy stays high across the retry.
- Undefined: no retry; the first outcome is reported directly.

Test Plan:
- tx_data=0xED, device model clocks at 12.5 kHz and ACKs → data bits on the line 1,0,1,1,0,1,1,1, parity=1. done=1, ack_err=0, timeout=0. clk_oe high for exactly 5000 cycles.
- tx_data=0x01 with ACK → parity bit 0. tx_data=0xFF → parity bit 1. Each ends with done and both oe=0.
- Device holds data=1 on the ACK clock → done=1 with ack_err=1. Under PS2_TX_RETRY_EN a second INHIBIT phase occurs first, and done is pulsed once, after the retry.
- Device never clocks after release → after 750000 cycles timeout=1, done=1, busy=0, both oe=0.
- rst_n=0 during SEND bit 4 → clk_oe=0 and data_oe=0 immediately, busy=0. A new tx_start after reset completes normally.
- tx_start pulsed again while busy → ignored. Only one frame appears on the line; the latched byte is unchanged.

Source files
------------

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, shift one byte, read device ACK.
// Optional PS2_TX_RETRY_EN: one automatic retry after a NACK or timeout before reporting.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYC = 5000,
  parameter int unsigned SETUP_CYC   = 50,
  parameter int unsigned TIMEOUT_CYC = 750000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2k_clk_in,
  input  logic       ps2k_data_in,
  output logic       ps2k_clk_oe,
  output logic       ps2k_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout
);

  localparam int unsigned PH_MAX = (INHIBIT_CYC > SETUP_CYC) ? INHIBIT_CYC : SETUP_CYC;
  localparam int unsigned CNT_W  = $clog2(PH_MAX + 1);
  localparam int unsigned TO_W   = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SEND, S_ACK, S_WAIT_IDLE
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [TO_W-1:0]    r_tcnt, w_tcnt_nxt;
  logic [3:0]         r_bit_cnt, w_bit_nxt;
  logic [9:0]         r_frame, w_frame_nxt;
  logic               r_nack, w_nack_nxt;
  logic               r_clk_oe, w_clk_oe_nxt;
  logic               r_data_oe, w_data_oe_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_done, w_done_nxt;
  logic               r_ack_err, w_ack_err_nxt;
  logic               r_timeout, w_timeout_nxt;
  logic [2:0]         r_clk_s;
  logic [1:0]         r_data_s;
  logic               w_fall, w_to_hit, w_end, w_end_nack, w_end_to;
`ifdef PS2_TX_RETRY_EN
  logic               r_retried, w_retried_nxt;
`endif

  // Pin synchronisers; third clock stage gives the falling-edge compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_s  <= 3'b111;
      r_data_s <= 2'b11;
    end else begin
      r_clk_s  <= {r_clk_s[1:0], ps2k_clk_in};
      r_data_s <= {r_data_s[0], ps2k_data_in};
    end
  end

  assign w_fall   = r_clk_s[2] & ~r_clk_s[1];
  assign w_to_hit = (r_tcnt == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_tcnt    <= '0;
      r_bit_cnt <= '0;
      r_frame   <= '0;
      r_nack    <= 1'b0;
      r_clk_oe  <= 1'b0;
      r_data_oe <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ack_err <= 1'b0;
      r_timeout <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      r_retried <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_tcnt    <= w_tcnt_nxt;
      r_bit_cnt <= w_bit_nxt;
      r_frame   <= w_frame_nxt;
      r_nack    <= w_nack_nxt;
      r_clk_oe  <= w_clk_oe_nxt;
      r_data_oe <= w_data_oe_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_ack_err <= w_ack_err_nxt;
      r_timeout <= w_timeout_nxt;
`ifdef PS2_TX_RETRY_EN
      r_retried <= w_retried_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_tcnt_nxt    = r_tcnt;
    w_bit_nxt     = r_bit_cnt;
    w_frame_nxt   = r_frame;
    w_nack_nxt    = r_nack;
    w_clk_oe_nxt  = r_clk_oe;
    w_data_oe_nxt = r_data_oe;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_ack_err_nxt = 1'b0;
    w_timeout_nxt = 1'b0;
    w_end         = 1'b0;
    w_end_nack    = 1'b0;
    w_end_to      = 1'b0;
`ifdef PS2_TX_RETRY_EN
    w_retried_nxt = r_retried;
`endif

    case (r_state)
      S_IDLE: begin
        w_clk_oe_nxt  = 1'b0;
        w_data_oe_nxt = 1'b0;
        if (tx_start) begin
          w_frame_nxt  = {1'b1, ~^tx_data, tx_data};
          w_busy_nxt   = 1'b1;
          w_cnt_nxt    = '0;
          w_clk_oe_nxt = 1'b1;
          w_state_nxt  = S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
          w_retried_nxt = 1'b0;
`endif
        end
      end
      S_INHIBIT: begin
        if (r_cnt == CNT_W'(INHIBIT_CYC - 1)) begin
          w_cnt_nxt     = '0;
          w_data_oe_nxt = 1'b1;
          w_state_nxt   = S_REQ;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_REQ: begin
        if (r_cnt == CNT_W'(SETUP_CYC - 1)) begin
          w_cnt_nxt    = '0;
          w_clk_oe_nxt = 1'b0;
          w_bit_nxt    = '0;
          w_tcnt_nxt   = '0;
          w_state_nxt  = S_SEND;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_SEND, S_ACK, S_WAIT_IDLE: begin
        w_tcnt_nxt = r_tcnt + TO_W'(1);
        if (w_to_hit) begin
          w_end    = 1'b1;
          w_end_to = 1'b1;
        end else if (r_state == S_SEND) begin
          if (w_fall) begin
            w_data_oe_nxt = ~r_frame[r_bit_cnt];
            w_bit_nxt     = r_bit_cnt + 4'd1;
            if (r_bit_cnt == 4'd9) w_state_nxt = S_ACK;
          end
        end else if (r_state == S_ACK) begin
          if (w_fall) begin
            w_nack_nxt  = r_data_s[1];
            w_state_nxt = S_WAIT_IDLE;
          end
        end else if (r_clk_s[1] && r_data_s[1]) begin
          w_end      = 1'b1;
          w_end_nack = r_nack;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Frame outcome: report and release, or (with retry) go round once more.
    if (w_end) begin
      w_state_nxt   = S_IDLE;
      w_clk_oe_nxt  = 1'b0;
      w_data_oe_nxt = 1'b0;
      w_busy_nxt    = 1'b0;
      w_done_nxt    = 1'b1;
      w_ack_err_nxt = w_end_nack;
      w_timeout_nxt = w_end_to;
`ifdef PS2_TX_RETRY_EN
      if (!r_retried && (w_end_nack || w_end_to)) begin
        w_retried_nxt = 1'b1;
        w_state_nxt   = S_INHIBIT;
        w_cnt_nxt     = '0;
        w_clk_oe_nxt  = 1'b1;
        w_busy_nxt    = 1'b1;
        w_done_nxt    = 1'b0;
        w_ack_err_nxt = 1'b0;
        w_timeout_nxt = 1'b0;
      end
`endif
    end
  end

  assign ps2k_clk_oe  = r_clk_oe;
  assign ps2k_data_oe = r_data_oe;
  assign busy         = r_busy;
  assign done         = r_done;
  assign ack_err      = r_ack_err;
  assign timeout      = r_timeout;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-collector device model, outcome scoreboard, per-cycle checks.
module tb_ps2_host_tx;

  localparam int unsigned INH = 40;
  localparam int unsigned SET = 8;
  localparam int unsigned TO  = 2000;
  localparam int unsigned H   = 15;
`ifdef PS2_TX_RETRY_EN
  localparam int TRIES = 2;
`else
  localparam int TRIES = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic tx_start = 1'b0;
  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;
  logic clk_oe, data_oe, busy, done, ack_err, timeout;
  logic clk_line, data_line;

  assign clk_line  = ~(clk_oe | dev_clk_low);
  assign data_line = ~(data_oe | dev_data_low);

  always #5 clk = ~clk;

  ps2_host_tx #(.INHIBIT_CYC(INH), .SETUP_CYC(SET), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_start(tx_start),
    .ps2k_clk_in(clk_line), .ps2k_data_in(data_line),
    .ps2k_clk_oe(clk_oe), .ps2k_data_oe(data_oe),
    .busy(busy), .done(done), .ack_err(ack_err), .timeout(timeout)
  );

  typedef struct { logic ack_err; logic to; } exp_t;
  exp_t exp_q[$];

  int checks = 0, failures = 0;
  int ncyc = 0, done_cnt = 0, inh_run = 0, req_run = 0;
  int last_inh = 0, last_req = 0, inh_phases = 0, fall_cyc = 0;
  logic prev_clk_oe = 1'b0;

  function automatic logic [9:0] frame_of(input logic [7:0] d);
    logic par;
    par = (($countones(d) % 2) == 0);
    return {1'b1, par, d};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle of time plus the per-cycle output checks against the outcome scoreboard.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    ncyc++;
    if (!rst_n) begin
      inh_run = 0; req_run = 0; prev_clk_oe = 1'b0;
      return;
    end
    if (clk_oe && !data_oe) inh_run++;
    else if (inh_run > 0) begin last_inh = inh_run; inh_phases++; inh_run = 0; end
    if (clk_oe && data_oe) req_run++;
    else if (req_run > 0) begin last_req = req_run; req_run = 0; end
    if (prev_clk_oe && !clk_oe) fall_cyc = ncyc;
    prev_clk_oe = clk_oe;
    if ((ack_err || timeout) && !done) check("pulse_without_done", 32'(done), 32'd1);
    if (done) begin
      done_cnt++;
      if (exp_q.size() == 0) check("unexpected_done", 32'(exp_q.size()), 32'd1);
      else begin
        e = exp_q.pop_front();
        check("ack_err_at_done", 32'(ack_err), 32'(e.ack_err));
        check("timeout_at_done", 32'(timeout), 32'(e.to));
        if (e.to) check("timeout_latency", 32'(ncyc - fall_cyc), 32'(TO));
      end
      check("busy_oe_at_done", {29'd0, busy, clk_oe, data_oe}, 32'd0);
    end
  endtask

  task automatic start_tx(input logic [7:0] d, input logic ea, input logic eto);
    exp_t e;
    e.ack_err = ea; e.to = eto;
    exp_q.push_back(e);
    check("clk_oe_before_start", 32'(clk_oe), 32'd0);
    tx_data = d; tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    check("clk_oe_one_cycle_after_start", {30'd0, clk_oe, data_oe}, 32'd2);
  endtask

  // Device side: wait for request-to-send, clock 10 bits in, then ACK (or not) on the 11th clock.
  task automatic dev_frame(input logic nack, input logic rst_mid, input logic poke,
                           output logic [9:0] bits, output logic ok);
    int i;
    ok = 1'b0; bits = '0; i = 0;
    while (!(clk_line && !data_line) && i < 2000) begin tick(); i++; end
    if (i >= 2000) begin check("rts_seen", 32'(data_line), 32'd0); return; end
    repeat (H) tick();
    for (int k = 0; k < 10; k++) begin
      dev_clk_low = 1'b1;
      repeat (H) tick();
      bits[k] = data_line;
      dev_clk_low = 1'b0;
      if (rst_mid && k == 3) begin
        #2 rst_n = 1'b0;
        #1 check("reset_mid_frame", {29'd0, busy, clk_oe, data_oe}, 32'd0);
        return;
      end
      if (k == 4) check("busy_mid_frame", 32'(busy), 32'd1);
      for (int j = 0; j < int'(H); j++) begin
        if (poke && k == 4) begin
          if (j == 0) begin tx_data = 8'h00; tx_start = 1'b1; end
          else if (j == 1) tx_start = 1'b0;
        end
        tick();
      end
    end
    if (!nack) dev_data_low = 1'b1;
    dev_clk_low = 1'b1;
    repeat (H) tick();
    dev_clk_low = 1'b0;
    repeat (H) tick();
    dev_data_low = 1'b0;
    ok = 1'b1;
  endtask

  task automatic wait_done(input int base);
    int i;
    i = 0;
    while (done_cnt == base && i < 3 * int'(INH + SET + TO)) begin tick(); i++; end
    check("done_count", 32'(done_cnt - base), 32'd1);
  endtask

  // mode: 0 = device ACKs, 1 = device NACKs, 2 = device silent
  task automatic run_txn(input logic [7:0] d, input int mode, input logic poke,
                         output logic [9:0] bits);
    int base_done, base_ph, tries;
    logic ok;
    base_done = done_cnt; base_ph = inh_phases;
    tries = (mode == 0) ? 1 : TRIES;
    bits = '0;
    start_tx(d, mode == 1, mode == 2);
    if (mode != 2) begin
      for (int t = 0; t < tries; t++) begin
        dev_frame(mode == 1, 1'b0, poke, bits, ok);
        check("device_frame_ok", 32'(ok), 32'd1);
        check("frame_bits", 32'(bits), 32'(frame_of(d)));
      end
    end
    wait_done(base_done);
    check("inhibit_len", 32'(last_inh), 32'(INH));
    check("setup_len", 32'(last_req), 32'(SET));
    check("inhibit_phases", 32'(inh_phases - base_ph), 32'(tries));
  endtask

  initial begin
    logic [9:0] bits;
    logic ok;
    int base_done, base_ph;

    repeat (3) @(negedge clk);
    check("reset_outputs", {26'd0, clk_oe, data_oe, busy, done, ack_err, timeout}, 32'd0);
    rst_n = 1'b1;
    repeat (3) tick();

    run_txn(8'hED, 0, 1'b0, bits);
    check("ed_line_bits", 32'(bits), 32'h3ED);
    check("ed_parity", 32'(bits[8]), 32'd1);
    run_txn(8'h01, 0, 1'b0, bits);
    check("x01_line_bits", 32'(bits), 32'h201);
    run_txn(8'hFF, 0, 1'b0, bits);
    check("xff_line_bits", 32'(bits), 32'h3FF);
    repeat (5) tick();
    check("idle_after_ack", {29'd0, busy, clk_oe, data_oe}, 32'd0);

    run_txn(8'hA5, 1, 1'b0, bits);
    repeat (5) tick();
    run_txn(8'h3C, 2, 1'b0, bits);
    repeat (5) tick();

    base_done = done_cnt;
    start_tx(8'h5A, 1'b0, 1'b0);
    dev_frame(1'b0, 1'b1, 1'b0, bits, ok);
    check("reset_frame_bits", 32'(bits[3:0]), 32'hA);
    repeat (4) tick();
    exp_q.delete();
    check("no_done_through_reset", 32'(done_cnt - base_done), 32'd0);
    rst_n = 1'b1;
    repeat (3) tick();
    run_txn(8'hC3, 0, 1'b0, bits);

    run_txn(8'h96, 0, 1'b1, bits);
    base_done = done_cnt; base_ph = inh_phases;
    repeat (200) tick();
    check("single_frame_phases", 32'(inh_phases - base_ph), 32'd0);
    check("single_frame_done", 32'(done_cnt - base_done), 32'd0);
    check("idle_after_poke", {29'd0, busy, clk_oe, data_oe}, 32'd0);

    repeat (5) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
